// File: rtl/morse_pkg.sv
// Shared types, constants and the pattern-to-letter table for the Morse decoder.
package morse_pkg;

    // Decoder FSM states; busy is simply state != IDLE.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRESS = 3'd1,
        GAP   = 3'd2,
        EMIT  = 3'd3,
        ERR   = 3'd4
    } state_t;

    // The segment encoder blanks every segment for this code.
    localparam logic [4:0] LETTER_BLANK = 5'd31;

    // Maps a collected pattern to {valid, letter index}. Symbols are packed
    // MSB-first in the low len bits of bits, dot = 0 and dash = 1.
    function automatic logic [5:0] morse_lut(input logic [2:0] len, input logic [3:0] bits);
        logic [5:0] r;
        r = {1'b0, LETTER_BLANK};
        case (len)
            3'd1: r = bits[0] ? {1'b1, 5'd19} : {1'b1, 5'd4};
            3'd2: begin
                case (bits[1:0])
                    2'b00:   r = {1'b1, 5'd8};
                    2'b01:   r = {1'b1, 5'd0};
                    2'b10:   r = {1'b1, 5'd13};
                    default: r = {1'b1, 5'd12};
                endcase
            end
            3'd3: begin
                case (bits[2:0])
                    3'b000:  r = {1'b1, 5'd18};
                    3'b001:  r = {1'b1, 5'd20};
                    3'b010:  r = {1'b1, 5'd17};
                    3'b011:  r = {1'b1, 5'd22};
                    3'b100:  r = {1'b1, 5'd3};
                    3'b101:  r = {1'b1, 5'd10};
                    3'b110:  r = {1'b1, 5'd6};
                    default: r = {1'b1, 5'd14};
                endcase
            end
            3'd4: begin
                case (bits)
                    4'b0000: r = {1'b1, 5'd7};
                    4'b0001: r = {1'b1, 5'd21};
                    4'b0010: r = {1'b1, 5'd5};
                    4'b0100: r = {1'b1, 5'd11};
                    4'b0110: r = {1'b1, 5'd15};
                    4'b0111: r = {1'b1, 5'd9};
                    4'b1000: r = {1'b1, 5'd1};
                    4'b1001: r = {1'b1, 5'd23};
                    4'b1010: r = {1'b1, 5'd2};
                    4'b1011: r = {1'b1, 5'd24};
                    4'b1100: r = {1'b1, 5'd25};
                    4'b1101: r = {1'b1, 5'd16};
                    default: r = {1'b0, LETTER_BLANK};
                endcase
            end
            default: r = {1'b0, LETTER_BLANK};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks.
module morse_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..TICK_DIV-1 and wrap; never stops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/morse_decoder.sv
// Single-key Morse decoder: times presses and gaps in ticks, collects up to
// four dots/dashes and emits the letter index after a letter gap.
// letter_valid and err are single-cycle pulses; letter holds its value between
// updates and can be read at any time.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int TICK_DIV  = 100000,
    parameter int MIN_TICKS = 10,
    parameter int DOT_MAX   = 200,
    parameter int GAP_TICKS = 600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key,
    output logic [4:0] letter,
    output logic       letter_valid,
    output logic       err,
    output logic       busy
);

    localparam int DW = $clog2(GAP_TICKS + 1);
    localparam logic [DW-1:0] DUR_MAX = '1;
    localparam logic [DW-1:0] GAP_T   = DW'(GAP_TICKS);
    localparam logic [DW-1:0] MIN_T   = DW'(MIN_TICKS);
    localparam logic [DW-1:0] DOT_T   = DW'(DOT_MAX);

    state_t        state;
    logic          key_m;
    logic          key_s;
    logic          key_d;
    logic          rise;
    logic          fall;
    logic          tick;
    logic [DW-1:0] dur;
    logic [3:0]    sym_bits;
    logic [2:0]    sym_len;
    logic [5:0]    lut_out;

    morse_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // Bring the raw key into the clock domain and keep a delayed copy for edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_m <= 1'b0;
            key_s <= 1'b0;
            key_d <= 1'b0;
        end else begin
            key_m <= key;
            key_s <= key_m;
            key_d <= key_s;
        end
    end

    assign rise    = key_s & ~key_d;
    assign fall    = ~key_s & key_d;
    assign lut_out = morse_lut(sym_len, sym_bits);
    assign busy    = (state != IDLE);

    // Main FSM: duration counter, symbol store and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            dur          <= '0;
            sym_bits     <= '0;
            sym_len      <= '0;
            letter       <= LETTER_BLANK;
            letter_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            letter_valid <= 1'b0;
            err          <= 1'b0;
            // Saturating tick count; every state entry below overrides it with 0.
            if (tick && (dur != DUR_MAX)) begin
                dur <= dur + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= PRESS;
                        dur   <= '0;
                    end
                end
                PRESS: begin
                    if (fall) begin
                        dur <= '0;
                        if (dur < MIN_T) begin
                            state <= (sym_len != 3'd0) ? GAP : IDLE;
                        end else if (sym_len == 3'd4) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else begin
                            sym_bits <= {sym_bits[2:0], (dur >= DOT_T)};
                            sym_len  <= sym_len + 3'd1;
                            state    <= GAP;
                        end
                    end
                end
                GAP: begin
                    // Gap expiry takes priority; EMIT then picks up a held key.
                    if (dur == GAP_T) begin
                        state <= EMIT;
                        dur   <= '0;
                    end else if (rise) begin
                        state <= PRESS;
                        dur   <= '0;
                    end
                end
                EMIT: begin
                    if (lut_out[5]) begin
                        letter       <= lut_out[4:0];
                        letter_valid <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                    sym_bits <= '0;
                    sym_len  <= '0;
                    dur      <= '0;
                    state    <= key_s ? PRESS : IDLE;
                end
                ERR: begin
                    // Only a continuous low of GAP_TICKS releases the error state.
                    if (key_s) begin
                        dur <= '0;
                    end else if (dur == GAP_T) begin
                        state    <= IDLE;
                        dur      <= '0;
                        sym_bits <= '0;
                        sym_len  <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    dur   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder with small timing parameters and a string-level
// Morse reference model.
module tb_morse_decoder;

    localparam int TD  = 4;
    localparam int GAP = 15;
    localparam int LAT_MIN = (GAP - 1) * TD;
    localparam int LAT_MAX = (GAP + 1) * TD + 8;

    logic       clk;
    logic       rst_n;
    logic       key;
    logic [4:0] letter;
    logic       letter_valid;
    logic       err;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rel_cyc = 0;
    logic [4:0] model_letter;
    logic [5:0] exp_q[$];
    logic [5:0] obs_q[$];

    string morse_tab [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                              ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                              "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    morse_decoder #(
        .TICK_DIV (TD),
        .MIN_TICKS(2),
        .DOT_MAX  (5),
        .GAP_TICKS(GAP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key         (key),
        .letter      (letter),
        .letter_valid(letter_valid),
        .err         (err),
        .busy        (busy)
    );

    // Clock and cycle count
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: record output events, check latency and letter hold on err.
    always @(negedge clk) begin
        if (rst_n) begin
            if (letter_valid && err) check("both_pulses", 1, 0);
            if (letter_valid) begin
                obs_q.push_back({1'b0, letter});
                check("latency", ((cyc - rel_cyc) >= LAT_MIN) && ((cyc - rel_cyc) <= LAT_MAX), 1);
            end
            if (err) begin
                obs_q.push_back(6'h20);
                check("err_hold", letter, model_letter);
            end
        end
    end

    // Drivers
    task automatic hold(input logic v, input int ticks);
        @(posedge clk);
        #1;
        if (key && !v) rel_cyc = cyc;
        key = v;
        repeat (ticks * TD - 1) @(posedge clk);
    endtask

    // Reference model: '.' dot, '-' dash, 'g' glitch (ignored).
    task automatic model_seq(input string s);
        int n;
        string pat;
        bit found;
        n = 0;
        pat = "";
        found = 0;
        for (int i = 0; i < s.len(); i++) begin
            if (s.substr(i, i) != "g") begin
                n++;
                if (n <= 4) pat = {pat, s.substr(i, i)};
            end
        end
        if (n > 4) begin
            exp_q.push_back(6'h20);
        end else if (n > 0) begin
            for (int k = 0; k < 26; k++) begin
                if (!found && morse_tab[k] == pat) begin
                    found = 1;
                    exp_q.push_back({1'b0, 5'(k)});
                    model_letter = 5'(k);
                end
            end
            if (!found) exp_q.push_back(6'h20);
        end
    endtask

    task automatic finish_letter();
        int m;
        check("evt_count", obs_q.size(), exp_q.size());
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) check("evt", obs_q[i], exp_q[i]);
        check("busy_idle", busy, 0);
        check("letter", letter, model_letter);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic send_seq(input string s, input bit rnd);
        model_seq(s);
        for (int i = 0; i < s.len(); i++) begin
            int t;
            if (i > 0) hold(1'b0, rnd ? int'($urandom_range(1, 8)) : 3);
            if (s.substr(i, i) == "g") t = 1;
            else if (s.substr(i, i) == ".") t = rnd ? int'($urandom_range(3, 4)) : 3;
            else t = rnd ? int'($urandom_range(6, 10)) : 8;
            hold(1'b1, t);
        end
        hold(1'b0, 20);
        finish_letter();
    endtask

    // Watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Main sequence
    initial begin
        bit seen_tt;
        bit got_m;
        bit got_tt;
        string s;
        key = 1'b0;
        rst_n = 1'b0;
        model_letter = 5'd31;
        seen_tt = 0;
        repeat (3) @(negedge clk);
        check("rst_letter", letter, 31);
        check("rst_valid", letter_valid, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Single dot -> E
        send_seq(".", 0);

        // Reset during a press discards everything and blanks the letter
        hold(1'b1, 3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2 * TD) @(posedge clk);
        #1;
        key = 1'b0;
        repeat (2 * TD) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_letter = 5'd31;
        repeat (20 * TD) @(posedge clk);
        #1;
        finish_letter();

        // Directed letters, glitch, invalid and over-long patterns
        send_seq(".-", 0);
        send_seq("--..", 0);
        send_seq(".g.", 0);
        send_seq("..--", 0);
        send_seq(".......", 0);
        send_seq(".", 0);
        send_seq("-", 0);

        // Randomized letters of 1..5 symbols with occasional glitches
        for (int r = 0; r < 40; r++) begin
            int n;
            n = $urandom_range(1, 5);
            s = "";
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 4) == 0) s = {s, "g"};
                if ($urandom_range(0, 1) == 1) s = {s, "-"};
                else s = {s, "."};
            end
            send_seq(s, 1);
        end

        // Sweep the second press across the gap expiry after T
        for (int off = 40; off <= 80; off++) begin
            hold(1'b1, 8);
            @(posedge clk);
            #1;
            rel_cyc = cyc;
            key = 1'b0;
            repeat (off - 1) @(posedge clk);
            #1;
            key = 1'b1;
            repeat (7 * TD - 1) @(posedge clk);
            #1;
            rel_cyc = cyc;
            key = 1'b0;
            repeat (20 * TD) @(posedge clk);
            #1;
            got_m  = (obs_q.size() == 1) && (obs_q[0] == 6'd12);
            got_tt = (obs_q.size() == 2) && (obs_q[0] == 6'd19) && (obs_q[1] == 6'd19);
            check("race_outcome", got_m || got_tt, 1);
            if (off <= 48) check("race_early", got_m, 1);
            if (off >= 74) check("race_late", got_tt, 1);
            check("race_order", seen_tt && got_m, 0);
            if (got_tt) seen_tt = 1;
            check("race_busy", busy, 0);
            obs_q.delete();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
